multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_perf_counter.sv | 34 +++
 rtl/multicycle_control.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM state codes, opcodes
// and the default performance-counter width.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [1:0] OP_RTYPE  = 2'b00;
   localparam logic [1:0] OP_LOAD   = 2'b01;
   localparam logic [1:0] OP_STORE  = 2'b10;
   localparam logic [1:0] OP_BRANCH = 2'b11;

   localparam int CNT_W_DEF = 16;

   function automatic logic is_mem_op(input logic [1:0] op_val);
      return (op_val == OP_LOAD) || (op_val == OP_STORE);
   endfunction

endpackage

// File: rtl/mc_perf_counter.sv
// Retired-instruction counter (wrapping) and memory-stall counter (saturating)
// for the multicycle controller.
module mc_perf_counter
   import mc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_retire,
   input  logic             i_stall,
   output logic [CNT_W-1:0] o_instr_count,
   output logic [CNT_W-1:0] o_stall_count
);

   logic [CNT_W-1:0] r_instr_count;
   logic [CNT_W-1:0] r_stall_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (i_retire)
            r_instr_count <= r_instr_count + CNT_W'(1);
         if (i_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign o_instr_count = r_instr_count;
   assign o_stall_count = r_stall_count;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational outputs.
// Optional performance counters are built when MC_PERF_EN is defined.
module multicycle_control
   import mc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             IorD,
   output logic             Branch,
   output logic             MemToReg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             ALUop,
   output logic             ALUsrc,
   output logic             RegWrite,
   output logic             RegDst,
   output logic [2:0]       state
`ifdef MC_PERF_EN
   ,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
`endif
);

   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_op_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_op_q  <= OP_RTYPE;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_DECODE)
            r_op_q <= op;
      end
   end

   always_comb begin
      w_state_next = r_state;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      IorD         = 1'b0;
      Branch       = 1'b0;
      MemToReg     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      ALUop        = 1'b0;
      ALUsrc       = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 1'b0;

      case (r_state)
         ST_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite      = 1'b1;
               PCWrite      = 1'b1;
               w_state_next = ST_DECODE;
            end
         end
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            ALUsrc = is_mem_op(r_op_q);
            ALUop  = (r_op_q == OP_RTYPE);
            if (r_op_q == OP_BRANCH) begin
               Branch       = 1'b1;
               PCWrite      = zero;
               w_state_next = ST_FETCH;
            end else if (r_op_q == OP_RTYPE) begin
               w_state_next = ST_WB;
            end else begin
               w_state_next = ST_MEM;
            end
         end
         ST_MEM: begin
            IorD     = 1'b1;
            MemRead  = (r_op_q == OP_LOAD);
            MemWrite = (r_op_q == OP_STORE);
            if (mem_ready)
               w_state_next = (r_op_q == OP_LOAD) ? ST_WB : ST_FETCH;
         end
         ST_WB: begin
            RegWrite     = 1'b1;
            RegDst       = (r_op_q == OP_RTYPE);
            MemToReg     = (r_op_q == OP_LOAD);
            w_state_next = ST_FETCH;
         end
         default: w_state_next = ST_FETCH;
      endcase

      // Reset overrides everything so an in-flight memory access is dropped at once.
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         IorD     = 1'b0;
         Branch   = 1'b0;
         MemToReg = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         ALUop    = 1'b0;
         ALUsrc   = 1'b0;
         RegWrite = 1'b0;
         RegDst   = 1'b0;
      end
   end

   assign state = r_state;

`ifdef MC_PERF_EN
   logic w_retire;
   logic w_stall;

   assign w_retire = (w_state_next == ST_FETCH) &&
                     ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB));
   assign w_stall  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

   mc_perf_counter #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk           (clk),
      .reset         (reset),
      .i_retire      (w_retire),
      .i_stall       (w_stall),
      .o_instr_count (instr_count),
      .o_stall_count (stall_count)
   );
`endif

endmodule
